fifo_stream_drain: RTL
======================

// Module: fifo_stream_drain
// PURPOSE
// - Read-side adapter directly downstream of the fifo block.
// - Turns the fifo's rd_en/empty/data_out pull interface, which has 1-cycle read latency, into a valid/ready stream.
// - Holds beats in a 2-entry skid buffer, so one beat per cycle is sustained and no beat is ever lost under backpressure.
// - The consumer sees in-order data with a registered out_valid/out_data.
// PARAMETERS
// - FIFO_WIDTH  8   data width; must match the fifo's FIFO_WIDTH
// - CNT_W       16  width of beat_cnt; used only when FIFO_DRAIN_CNT_EN is defined
// PORTS
// - clk        in   1           single clock; all state on posedge
// - rstN       in   1           asynchronous, active-low reset
// - empty      in   1           fifo empty flag
// - data_out   in   FIFO_WIDTH  fifo read data; valid the cycle after an accepted rd_en
// - rd_en      out  1           fifo read request
// - out_valid  out  1           stream beat valid
// - out_ready  in   1           stream consumer ready
// - out_data   out  FIFO_WIDTH  stream beat data
// - beat_cnt   out  CNT_W       accepted-beat count; present only with FIFO_DRAIN_CNT_EN
// BEHAVIOUR
// - Reset (rstN=0, async): buffer occupancy occ=0, pending=0, out_valid=0, out_data=0, beat_cnt=0.
//   - rd_en is forced to 0 while rstN=0.
// - Read issue: rd_en = rstN & !empty & ((occ + pending - pop) < 2).
//   - pending = registered rd_en, i.e. a read is in flight.
//   - pop = out_valid & out_ready.
//   - The combinational path out_ready -> rd_en is intentional; it gives full throughput.
// - Capture: when pending=1, data_out is written into the buffer tail in that cycle.
//   - rd_en is never asserted while empty=1, so every pending read returns real data.
// - Buffer states, named by occ:
//   - S0 (empty): out_valid=0.
//     - Capture -> S1.
//   - S1 (1 beat): head drives out_data; out_valid=1.
//     - Capture, no pop -> S2.
//     - Pop, no capture -> S0.
//     - Capture and pop together -> S1; the new beat becomes head.
//   - S2 (full): head and tail held.
//     - Pop -> S1; tail shifts to head.
//     - A capture in S2 is impossible by the issue rule.
//     - The bench must flag any capture in S2 as an assertion failure.
// - Stream rules:
//   - out_valid and out_data are registered.
//   - Once out_valid=1, out_data and out_valid stay stable until pop.
//   - A beat transfers on the posedge where out_valid & out_ready.
// - Latency: fifo non-empty with the buffer idle and out_ready=1 -> rd_en same cycle -> out_valid two cycles later.
// - Throughput: 1 beat/cycle while out_ready=1 and the fifo stays non-empty.
// - Boundaries:
//   - fifo goes empty mid-burst: rd_en drops the same cycle; in-flight beat still captured; out_valid falls after the last pop.
//   - out_ready low: at most 2 beats buffered; rd_en=0 until a pop frees space.
//   - rstN asserted mid-transfer: buffered and in-flight beats are discarded; the fifo is reset by the same rstN.
//   - out_ready with out_valid=0: ignored.
// CONFIGURATION
// - FIFO_DRAIN_CNT_EN defined:
//   - beat_cnt increments by 1 on every pop and wraps modulo 2**CNT_W.
//   - Reset value 0.
// - FIFO_DRAIN_CNT_EN undefined:
//   - beat_cnt port and counter logic are absent.
//   - All other behaviour is identical.
// TESTING
// - Reset: hold rstN=0 with empty=0 -> rd_en=0, out_valid=0, out_data=0 throughout; after release, first rd_en occurs when empty=0.
// - Streaming: fifo preloaded with 0x01..0x10, out_ready=1 -> 16 beats 0x01..0x10 on 16 consecutive cycles, in order, no gaps after the first.
// - Backpressure: preload 0xA0..0xA7, out_ready=0 for 10 cycles -> exactly 2 rd_en pulses, out_data=0xA0 held stable; release -> 0xA0..0xA7 in order, no loss or duplication.
// - Empty mid-burst: fifo holds 3 entries, out_ready=1 -> exactly 3 rd_en pulses, never with empty=1; out_valid deasserts after the 3rd beat.
// - Reset mid-operation: 2 beats buffered, pulse rstN low 1 cycle -> out_valid=0 immediately; the next beat out is the first word written after reset.
// - Counter (FIFO_DRAIN_CNT_EN, CNT_W=4): 18 accepted beats -> beat_cnt=2 (wrapped); without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: read-side adapter that turns a fifo pull interface
// (rd_en / empty / data_out with 1-cycle read latency) into a valid/ready
// stream through a 2-entry skid buffer.
//
// Optional feature macro: FIFO_DRAIN_CNT_EN
//   defined   -> beat_cnt output counts accepted beats, wrapping modulo 2**CNT_W
//   undefined -> no beat_cnt port and no counter logic
//
// Handshake: a beat transfers on the posedge where out_valid & out_ready are
// both high. out_valid/out_data are registered and stay stable until that
// transfer. out_ready while out_valid is low has no effect.
module fifo_stream_drain #(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  empty,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_W-1:0]      beat_cnt
`endif
);

    // Buffer occupancy states; the encoding equals the number of held beats.
    typedef enum logic [1:0] {
        S0 = 2'd0,   // no beats held
        S1 = 2'd1,   // head valid
        S2 = 2'd2    // head and tail valid
    } state_e;

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [FIFO_WIDTH-1:0]   head_q, head_d;
    logic [FIFO_WIDTH-1:0]   tail_q, tail_d;
    logic                    out_valid_q, out_valid_d;

    logic                    pop;
    logic                    cap;
    logic [1:0]              occ;
    logic [2:0]              occ_after;

    // Widths below one bit are not a legal configuration; nothing to build.
    if (FIFO_WIDTH < 1 || CNT_W < 1) begin : g_bad_width
    end

    // A beat leaves when the consumer takes it; a read returns when one is in flight.
    always_comb begin
        pop       = out_valid_q & out_ready;
        cap       = pending_q;
        occ       = state_q;
        occ_after = {1'b0, occ} + {2'b00, pending_q} - {2'b00, pop};
    end

    // Issue a read only when the beat it returns is guaranteed a slot.
    // The out_ready -> rd_en path is combinational on purpose so that a pop
    // in the same cycle frees space for a new read (full throughput).
    always_comb begin
        rd_en = rstN & ~empty & (occ_after < 3'd2);
    end

    // Next-state and data movement for the skid buffer.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pending_d   = rd_en;
        out_valid_d = 1'b0;

        case (state_q)
            S0: begin
                if (cap) begin
                    state_d = S1;
                    head_d  = data_out;
                end
            end
            S1: begin
                case ({cap, pop})
                    2'b10: begin
                        state_d = S2;
                        tail_d  = data_out;
                    end
                    2'b01: begin
                        state_d = S0;
                    end
                    2'b11: begin
                        // Head leaves and the arriving beat replaces it.
                        state_d = S1;
                        head_d  = data_out;
                    end
                    default: begin
                        state_d = S1;
                    end
                endcase
            end
            S2: begin
                // The issue rule keeps a capture from ever landing here.
                if (pop) begin
                    state_d = S1;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = S0;
            end
        endcase

        out_valid_d = (state_d != S0);
    end

    // State, buffer and registered stream outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S0;
            pending_q   <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q;

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Count accepted beats; wraps naturally at 2**CNT_W.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Accepted-beat counter register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
